// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: regenerates round keys 10..0 from the round-10 key, one per handshake.
// Optional AES_INV_MIXCOL_KEY_EN: rounds 1..9 are emitted as equivalent-inverse-cipher keys.

module sbox (
  input  logic [7:0] sbin,
  output logic [7:0] sbout
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbout = SBOX_TABLE[(255 - int'(sbin)) * 8 +: 8];

endmodule

module aes_inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_XOR,
    S_SUB,
    S_FIN
  } state_t;

  state_t      state;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sub_reg;
  logic [3:0]  round;
  logic [31:0] rot_w;
  logic [31:0] sub_w;

  assign rot_w = {k3[23:0], k3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .sbin  (rot_w[8*b +: 8]),
      .sbout (sub_w[8*b +: 8])
    );
  end

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      sub_reg  <= '0;
      round    <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // the done cycle itself still counts as the tail of the previous run
          if (start && !done) begin
            {k0, k1, k2, k3} <= last_key;
            round    <= 4'(NR);
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (round == 4'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_XOR;
            end
          end
        end
        S_XOR: begin
          k3    <= k3 ^ k2;
          k2    <= k2 ^ k1;
          k1    <= k1 ^ k0;
          state <= S_SUB;
        end
        S_SUB: begin
          sub_reg <= sub_w;
          state   <= S_FIN;
        end
        S_FIN: begin
          k0       <= k0 ^ sub_reg ^ {rcon(round), 24'h000000};
          round    <= round - 4'd1;
          rk_valid <= 1'b1;
          state    <= S_EMIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rk_round = round;

`ifdef AES_INV_MIXCOL_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  // first and last round keys are used raw by the equivalent inverse cipher
  assign rk_data = (round != 4'd0 && round != 4'(NR))
                   ? {inv_mix(k0), inv_mix(k1), inv_mix(k2), inv_mix(k3)}
                   : {k0, k1, k2, k3};
`else
  assign rk_data = {k0, k1, k2, k3};
`endif

endmodule
